// File: rtl/mmu_arbiter.sv
// mmu_arbiter: owner of the single shared 16-bit SRAM.
// Instruction fetch at the current PC is served every cycle in FETCH. MEM-stage loads and stores
// take priority. While a data access holds the bus, vmem_pause_o freezes the PC and the pipeline.
// Each data access ends with a one-cycle mem_done_o pulse, which falls in a FETCH cycle.
// Optional feature: define MMU_UART_EN to map data addresses 0xBF00/0xBF01 onto the UART.
// Without it, every address goes to the SRAM and the UART strobes are tied low.

module mmu_arbiter #(
  parameter logic [15:0] NOP_INST = 16'h0800,
  parameter int unsigned RAM_AW   = 18
) (
  input  logic              clk,
  input  logic              rst,

  // Instruction fetch port
  input  logic [15:0]       if_addr_i,
  input  logic              if_pause_i,
  output logic [15:0]       if_inst_o,

  // MEM-stage data port
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [15:0]       mem_addr_i,
  input  logic [15:0]       mem_wdata_i,
  output logic [15:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic              vmem_pause_o,

  // SRAM pins
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [15:0]       ram_data_o,
  input  logic [15:0]       ram_data_i,
  output logic              ram_data_oe,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,

  // UART
  output logic              uart_rd_o,
  output logic              uart_wr_o,
  input  logic [7:0]        uart_rdata_i,
  input  logic              uart_ready_i,
  input  logic              uart_tx_idle_i
);

  typedef enum logic [2:0] {
    StFetch,
    StMemRd,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StUartRd,
    StUartWr
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        accept;

  // The done cycle blocks acceptance, so a request left high across done cannot retrigger.
  assign accept       = mem_req_i & ~done_q & (state_q == StFetch);
  assign vmem_pause_o = (state_q != StFetch) | accept;

  assign if_inst_o   = inst_q;
  assign mem_rdata_o = rdata_q;
  assign mem_done_o  = done_q;

`ifdef MMU_UART_EN
  logic uart_hit;
  // 0xBF00 (data) and 0xBF01 (status) differ only in bit 0.
  assign uart_hit = (mem_addr_i[15:1] == 15'h5F80);
`else
  logic unused_uart;
  assign unused_uart = ^{uart_rdata_i, uart_ready_i, uart_tx_idle_i};
`endif

  // Next-state and register-update logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    inst_d  = inst_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    case (state_q)
      StFetch: begin
        if (accept) begin
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          state_d = mem_we_i ? StWrSetup : StMemRd;
`ifdef MMU_UART_EN
          if (uart_hit) begin
            state_d = mem_we_i ? StUartWr : StUartRd;
          end
`endif
        end else if (!if_pause_i) begin
          inst_d = ram_data_i;
        end
      end
      StMemRd: begin
        rdata_d = ram_data_i;
        done_d  = 1'b1;
        state_d = StFetch;
      end
      StWrSetup: state_d = StWrPulse;
      StWrPulse: state_d = StWrHold;
      StWrHold: begin
        done_d  = 1'b1;
        state_d = StFetch;
      end
`ifdef MMU_UART_EN
      StUartRd: begin
        // Bit 0 selects the status word instead of the receive byte.
        rdata_d = addr_q[0] ? {14'b0, uart_ready_i, uart_tx_idle_i} : {8'b0, uart_rdata_i};
        done_d  = 1'b1;
        state_d = StFetch;
      end
      StUartWr: begin
        done_d  = 1'b1;
        state_d = StFetch;
      end
`endif
      default: state_d = StFetch;
    endcase
  end

  // SRAM and UART strobes are decoded from the state.
  // Reset therefore releases we_n on the same edge that aborts an access.
  always_comb begin
    ram_addr_o  = RAM_AW'(if_addr_i);
    ram_data_o  = wdata_q;
    ram_data_oe = 1'b0;
    ram_ce_n    = 1'b0;
    ram_oe_n    = 1'b0;
    ram_we_n    = 1'b1;
    uart_rd_o   = 1'b0;
    uart_wr_o   = 1'b0;
    case (state_q)
      StFetch: ;
      StMemRd: ram_addr_o = RAM_AW'(addr_q);
      StWrSetup, StWrHold: begin
        ram_addr_o  = RAM_AW'(addr_q);
        ram_data_oe = 1'b1;
        ram_oe_n    = 1'b1;
      end
      StWrPulse: begin
        ram_addr_o  = RAM_AW'(addr_q);
        ram_data_oe = 1'b1;
        ram_oe_n    = 1'b1;
        ram_we_n    = 1'b0;
      end
`ifdef MMU_UART_EN
      StUartRd: begin
        ram_addr_o = RAM_AW'(addr_q);
        ram_ce_n   = 1'b1;
        ram_oe_n   = 1'b1;
        uart_rd_o  = ~addr_q[0];
      end
      StUartWr: begin
        // The UART shares the data bus, so the store byte is driven on ram_data_o.
        // A store to the status address only completes.
        ram_addr_o  = RAM_AW'(addr_q);
        ram_ce_n    = 1'b1;
        ram_oe_n    = 1'b1;
        ram_data_oe = ~addr_q[0];
        uart_wr_o   = ~addr_q[0];
      end
`endif
      default: ;
    endcase
  end

  // State and datapath registers; synchronous reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      inst_q  <= NOP_INST;
      rdata_q <= 16'h0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      inst_q  <= inst_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_mmu_arbiter.sv
// Testbench for mmu_arbiter.
// A behavioural SRAM answers the DUT's strobes. A separate reference memory, updated from the
// stimulus, predicts every fetched and loaded word.
module tb_mmu_arbiter;

  localparam logic [15:0] Nop = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] if_addr_i;
  logic        if_pause_i;
  logic [15:0] if_inst_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [15:0] mem_addr_i;
  logic [15:0] mem_wdata_i;
  logic [15:0] mem_rdata_o;
  logic        mem_done_o;
  logic        vmem_pause_o;
  logic [17:0] ram_addr_o;
  logic [15:0] ram_data_o;
  logic [15:0] ram_data_i;
  logic        ram_data_oe;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic        uart_rd_o;
  logic        uart_wr_o;
  logic [7:0]  uart_rdata_i;
  logic        uart_ready_i;
  logic        uart_tx_idle_i;

  mmu_arbiter #(.NOP_INST(Nop), .RAM_AW(18)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_addr_i      (if_addr_i),
    .if_pause_i     (if_pause_i),
    .if_inst_o      (if_inst_o),
    .mem_req_i      (mem_req_i),
    .mem_we_i       (mem_we_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_rdata_o    (mem_rdata_o),
    .mem_done_o     (mem_done_o),
    .vmem_pause_o   (vmem_pause_o),
    .ram_addr_o     (ram_addr_o),
    .ram_data_o     (ram_data_o),
    .ram_data_i     (ram_data_i),
    .ram_data_oe    (ram_data_oe),
    .ram_ce_n       (ram_ce_n),
    .ram_oe_n       (ram_oe_n),
    .ram_we_n       (ram_we_n),
    .uart_rd_o      (uart_rd_o),
    .uart_wr_o      (uart_wr_o),
    .uart_rdata_i   (uart_rdata_i),
    .uart_ready_i   (uart_ready_i),
    .uart_tx_idle_i (uart_tx_idle_i)
  );

  always #5 clk = ~clk;

  logic [15:0] sram    [0:65535];  // physical SRAM contents, written only by the DUT's strobes
  logic [15:0] ref_mem [0:65535];  // what the program expects memory to hold
  logic [15:0] exp_inst;
  int          n_vec;
  int          n_err;

  assign ram_data_i = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr_o[15:0]] : 16'h0000;

  // One clock: the SRAM model latches a write mid-cycle; outputs are sampled 1 after posedge.
  task automatic cycle();
    @(negedge clk);
    if (!ram_ce_n && !ram_we_n && ram_data_oe) sram[ram_addr_o[15:0]] = ram_data_o;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick_addr();
    logic [15:0] a;
    a = 16'($urandom);
    if (a[15:1] == 15'h5F80) a = a ^ 16'h0100;
    return a;
  endfunction

  task automatic test_reset();
    rst = 1'b1; mem_req_i = 1'b0; if_pause_i = 1'b0; if_addr_i = 16'h0004;
    sram[4] = 16'h4801; ref_mem[4] = 16'h4801;
    cycle(); cycle();
    n_vec++; if (if_inst_o !== Nop) begin n_err++; $display("FAIL rst_inst: got %h want %h", if_inst_o, Nop); end
    n_vec++; if (mem_done_o !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", mem_done_o); end
    n_vec++; if (mem_rdata_o !== 16'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", mem_rdata_o); end
    n_vec++; if ({ram_we_n, ram_oe_n, ram_ce_n, ram_data_oe} !== 4'b1000) begin
      n_err++; $display("FAIL rst_strobes: got we/oe/ce/doe=%b want 1000", {ram_we_n, ram_oe_n, ram_ce_n, ram_data_oe}); end
    n_vec++; if ({uart_rd_o, uart_wr_o} !== 2'b00) begin n_err++; $display("FAIL rst_uart: got %b want 00", {uart_rd_o, uart_wr_o}); end
    rst = 1'b0;
    #1;
    n_vec++; if (if_inst_o !== Nop) begin n_err++; $display("FAIL pre_edge_inst: got %h want %h", if_inst_o, Nop); end
    n_vec++; if (vmem_pause_o !== 1'b0) begin n_err++; $display("FAIL idle_pause: got %b want 0", vmem_pause_o); end
    cycle();
    exp_inst = 16'h4801;
    n_vec++; if (if_inst_o !== exp_inst) begin n_err++; $display("FAIL first_fetch: got %h want %h", if_inst_o, exp_inst); end
  endtask

  task automatic test_fetch(input int n);
    for (int i = 0; i < n; i++) begin
      if_addr_i  = 16'($urandom);
      if_pause_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        sram[if_addr_i] = 16'($urandom); ref_mem[if_addr_i] = sram[if_addr_i];
      end
      #1;
      n_vec++; if (ram_addr_o !== 18'(if_addr_i)) begin n_err++; $display("FAIL fetch_addr: got %h want %h", ram_addr_o, 18'(if_addr_i)); end
      cycle();
      if (!if_pause_i) exp_inst = ref_mem[if_addr_i];
      n_vec++; if (if_inst_o !== exp_inst) begin n_err++; $display("FAIL fetch_inst: got %h want %h", if_inst_o, exp_inst); end
    end
    if_pause_i = 1'b0;
  endtask

  task automatic test_pause_hold();
    if_pause_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sram[if_addr_i] = 16'($urandom); ref_mem[if_addr_i] = sram[if_addr_i];
      cycle();
      n_vec++; if (if_inst_o !== exp_inst) begin n_err++; $display("FAIL pause_hold: got %h want %h", if_inst_o, exp_inst); end
    end
    if_pause_i = 1'b0;
    cycle();
    exp_inst = ref_mem[if_addr_i];
    n_vec++; if (if_inst_o !== exp_inst) begin n_err++; $display("FAIL pause_release: got %h want %h", if_inst_o, exp_inst); end
  endtask

  task automatic test_load(input logic [15:0] a);
    logic [15:0] want;
    want = ref_mem[a];
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = a; mem_wdata_i = 16'($urandom); if_pause_i = 1'b0;
    #1;
    n_vec++; if (vmem_pause_o !== 1'b1) begin n_err++; $display("FAIL ld_accept_pause: got %b want 1", vmem_pause_o); end
    cycle();
    n_vec++; if (vmem_pause_o !== 1'b1) begin n_err++; $display("FAIL ld_busy_pause: got %b want 1", vmem_pause_o); end
    n_vec++; if (ram_addr_o !== 18'(a)) begin n_err++; $display("FAIL ld_addr: got %h want %h", ram_addr_o, 18'(a)); end
    n_vec++; if ({mem_done_o, ram_oe_n, ram_we_n} !== 3'b001) begin
      n_err++; $display("FAIL ld_strobes: got done/oe/we=%b want 001", {mem_done_o, ram_oe_n, ram_we_n}); end
    n_vec++; if ({uart_rd_o, uart_wr_o} !== 2'b00) begin n_err++; $display("FAIL ld_uart: got %b want 00", {uart_rd_o, uart_wr_o}); end
    n_vec++; if (if_inst_o !== exp_inst) begin n_err++; $display("FAIL ld_inst_hold: got %h want %h", if_inst_o, exp_inst); end
    cycle();
    n_vec++; if (mem_done_o !== 1'b1) begin n_err++; $display("FAIL ld_done: got %b want 1", mem_done_o); end
    n_vec++; if (mem_rdata_o !== want) begin n_err++; $display("FAIL ld_data: got %h want %h", mem_rdata_o, want); end
    n_vec++; if (vmem_pause_o !== 1'b0) begin n_err++; $display("FAIL ld_done_pause: got %b want 0", vmem_pause_o); end
    n_vec++; if (if_inst_o !== exp_inst) begin n_err++; $display("FAIL ld_inst_done: got %h want %h", if_inst_o, exp_inst); end
    mem_req_i = 1'b0;
    cycle();
    exp_inst = ref_mem[if_addr_i];
    n_vec++; if (mem_done_o !== 1'b0) begin n_err++; $display("FAIL ld_done_width: got %b want 0", mem_done_o); end
    n_vec++; if (mem_rdata_o !== want) begin n_err++; $display("FAIL ld_data_held: got %h want %h", mem_rdata_o, want); end
    n_vec++; if (if_inst_o !== exp_inst) begin n_err++; $display("FAIL ld_refetch: got %h want %h", if_inst_o, exp_inst); end
  endtask

  task automatic test_store(input logic [15:0] a, input logic [15:0] d);
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = a; mem_wdata_i = d; if_pause_i = 1'b0;
    #1;
    n_vec++; if (vmem_pause_o !== 1'b1) begin n_err++; $display("FAIL st_accept_pause: got %b want 1", vmem_pause_o); end
    cycle();
    n_vec++; if ({ram_data_oe, ram_oe_n, ram_we_n, ram_ce_n} !== 4'b1110) begin
      n_err++; $display("FAIL st_setup: got doe/oe/we/ce=%b want 1110", {ram_data_oe, ram_oe_n, ram_we_n, ram_ce_n}); end
    n_vec++; if (ram_addr_o !== 18'(a)) begin n_err++; $display("FAIL st_addr: got %h want %h", ram_addr_o, 18'(a)); end
    n_vec++; if (ram_data_o !== d) begin n_err++; $display("FAIL st_wdata: got %h want %h", ram_data_o, d); end
    cycle();
    n_vec++; if ({ram_data_oe, ram_we_n, vmem_pause_o} !== 3'b101) begin
      n_err++; $display("FAIL st_pulse: got doe/we/pause=%b want 101", {ram_data_oe, ram_we_n, vmem_pause_o}); end
    cycle();
    n_vec++; if ({ram_data_oe, ram_we_n, mem_done_o} !== 3'b110) begin
      n_err++; $display("FAIL st_hold: got doe/we/done=%b want 110", {ram_data_oe, ram_we_n, mem_done_o}); end
    n_vec++; if (if_inst_o !== exp_inst) begin n_err++; $display("FAIL st_inst_hold: got %h want %h", if_inst_o, exp_inst); end
    cycle();
    ref_mem[a] = d;
    n_vec++; if ({mem_done_o, ram_data_oe, vmem_pause_o} !== 3'b100) begin
      n_err++; $display("FAIL st_done: got done/doe/pause=%b want 100", {mem_done_o, ram_data_oe, vmem_pause_o}); end
    mem_req_i = 1'b0;
    cycle();
    exp_inst = ref_mem[if_addr_i];
    n_vec++; if (mem_done_o !== 1'b0) begin n_err++; $display("FAIL st_done_width: got %b want 0", mem_done_o); end
    n_vec++; if (if_inst_o !== exp_inst) begin n_err++; $display("FAIL st_refetch: got %h want %h", if_inst_o, exp_inst); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a1, a2, d2;
    a1 = pick_addr(); a2 = pick_addr(); d2 = 16'($urandom);
    if_addr_i = a1 ^ 16'h0001;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = a1; if_pause_i = 1'b0;
    cycle(); cycle();
    n_vec++; if (mem_done_o !== 1'b1) begin n_err++; $display("FAIL b2b_done1: got %b want 1", mem_done_o); end
    n_vec++; if (mem_rdata_o !== ref_mem[a1]) begin n_err++; $display("FAIL b2b_data1: got %h want %h", mem_rdata_o, ref_mem[a1]); end
    mem_we_i = 1'b1; mem_addr_i = a2; mem_wdata_i = d2;  // request stays high
    #1;
    n_vec++; if (vmem_pause_o !== 1'b0) begin n_err++; $display("FAIL b2b_no_retrigger: got %b want 0", vmem_pause_o); end
    cycle();
    exp_inst = ref_mem[if_addr_i];
    n_vec++; if (ram_addr_o !== 18'(if_addr_i)) begin n_err++; $display("FAIL b2b_fetch_addr: got %h want %h", ram_addr_o, 18'(if_addr_i)); end
    n_vec++; if ({mem_done_o, ram_data_oe, vmem_pause_o} !== 3'b001) begin
      n_err++; $display("FAIL b2b_gap: got done/doe/pause=%b want 001", {mem_done_o, ram_data_oe, vmem_pause_o}); end
    n_vec++; if (if_inst_o !== exp_inst) begin n_err++; $display("FAIL b2b_inst: got %h want %h", if_inst_o, exp_inst); end
    cycle();
    n_vec++; if ({ram_data_oe, ram_we_n} !== 2'b11 || ram_addr_o !== 18'(a2)) begin
      n_err++; $display("FAIL b2b_setup: got doe/we=%b addr=%h want 11 addr=%h", {ram_data_oe, ram_we_n}, ram_addr_o, 18'(a2)); end
    cycle();
    n_vec++; if (ram_we_n !== 1'b0) begin n_err++; $display("FAIL b2b_pulse: got %b want 0", ram_we_n); end
    cycle(); cycle();
    ref_mem[a2] = d2;
    n_vec++; if (mem_done_o !== 1'b1) begin n_err++; $display("FAIL b2b_done2: got %b want 1", mem_done_o); end
    mem_req_i = 1'b0;
    cycle();
    exp_inst = ref_mem[if_addr_i];
    test_load(a2);
  endtask

  task automatic test_random_traffic(input int n);
    logic [15:0] pool [6];
    for (int i = 0; i < 6; i++) pool[i] = pick_addr();
    for (int i = 0; i < n; i++) begin
      if_addr_i = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : 16'($urandom);
      if ($urandom_range(0, 1) == 1) test_store(pool[$urandom_range(0, 5)], 16'($urandom));
      else test_load(pool[$urandom_range(0, 5)]);
      if ($urandom_range(0, 2) == 0) begin
        cycle();
        exp_inst = ref_mem[if_addr_i];
        n_vec++; if (if_inst_o !== exp_inst) begin n_err++; $display("FAIL rand_idle_fetch: got %h want %h", if_inst_o, exp_inst); end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] a, d;
    a = pick_addr(); d = 16'($urandom);
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = a; mem_wdata_i = d;
    cycle(); cycle();
    n_vec++; if (ram_we_n !== 1'b0) begin n_err++; $display("FAIL rw_pulse: got %b want 0", ram_we_n); end
    rst = 1'b1; mem_req_i = 1'b0;
    cycle();
    ref_mem[a] = d;  // the write strobe had already been low for a full cycle
    exp_inst = Nop;
    n_vec++; if ({ram_we_n, mem_done_o, ram_data_oe, vmem_pause_o} !== 4'b1000) begin
      n_err++; $display("FAIL rw_abort: got we/done/doe/pause=%b want 1000", {ram_we_n, mem_done_o, ram_data_oe, vmem_pause_o}); end
    n_vec++; if (if_inst_o !== exp_inst) begin n_err++; $display("FAIL rw_inst: got %h want %h", if_inst_o, exp_inst); end
    rst = 1'b0;
    cycle();
    exp_inst = ref_mem[if_addr_i];
    n_vec++; if (mem_done_o !== 1'b0) begin n_err++; $display("FAIL rw_no_done: got %b want 0", mem_done_o); end
    n_vec++; if (if_inst_o !== exp_inst) begin n_err++; $display("FAIL rw_fetch: got %h want %h", if_inst_o, exp_inst); end
  endtask

  task automatic test_uart();
`ifdef MMU_UART_EN
    logic [15:0] d;
    uart_ready_i = 1'b1; uart_tx_idle_i = 1'b1; uart_rdata_i = 8'($urandom); d = 16'($urandom);
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 16'hBF01;
    cycle();
    n_vec++; if ({ram_ce_n, ram_we_n, uart_rd_o} !== 3'b110) begin
      n_err++; $display("FAIL ua_stat_strobes: got ce/we/rd=%b want 110", {ram_ce_n, ram_we_n, uart_rd_o}); end
    cycle();
    n_vec++; if (mem_done_o !== 1'b1 || mem_rdata_o !== 16'h0003) begin
      n_err++; $display("FAIL ua_status: got done=%b data=%h want 1 0003", mem_done_o, mem_rdata_o); end
    mem_addr_i = 16'hBF00;
    cycle();
    cycle();
    n_vec++; if ({uart_rd_o, ram_ce_n} !== 2'b11) begin n_err++; $display("FAIL ua_rd_strobe: got rd/ce=%b want 11", {uart_rd_o, ram_ce_n}); end
    cycle();
    n_vec++; if (mem_rdata_o !== {8'h00, uart_rdata_i} || uart_rd_o !== 1'b0) begin
      n_err++; $display("FAIL ua_rdata: got %h rd=%b want %h rd=0", mem_rdata_o, uart_rd_o, {8'h00, uart_rdata_i}); end
    mem_we_i = 1'b1; mem_wdata_i = d;
    cycle();
    cycle();
    n_vec++; if ({uart_wr_o, ram_we_n, ram_ce_n} !== 3'b111 || ram_data_o !== d) begin
      n_err++; $display("FAIL ua_wr: got wr/we/ce=%b data=%h want 111 %h", {uart_wr_o, ram_we_n, ram_ce_n}, ram_data_o, d); end
    cycle();
    n_vec++; if ({mem_done_o, uart_wr_o, ram_we_n} !== 3'b101) begin
      n_err++; $display("FAIL ua_wr_done: got done/wr/we=%b want 101", {mem_done_o, uart_wr_o, ram_we_n}); end
    mem_req_i = 1'b0;
    cycle();
    exp_inst = ref_mem[if_addr_i];
`else
    // Without the UART map, 0xBF00 is ordinary SRAM and the UART strobes never move.
    test_store(16'hBF00, 16'($urandom));
    test_load(16'hBF00);
`endif
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    for (int i = 0; i < 65536; i++) begin
      sram[i] = 16'($urandom);
      ref_mem[i] = sram[i];
    end
    rst = 1'b1; if_addr_i = 16'h0; if_pause_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
    mem_addr_i = 16'h0; mem_wdata_i = 16'h0; uart_rdata_i = 8'h0; uart_ready_i = 1'b0;
    uart_tx_idle_i = 1'b0; exp_inst = Nop;
    test_reset();
    test_fetch(24);
    test_pause_hold();
    sram[16'h0100] = 16'hBEEF; ref_mem[16'h0100] = 16'hBEEF;
    test_load(16'h0100);
    test_store(16'h0200, 16'h1234);
    test_load(16'h0200);
    test_back_to_back();
    test_random_traffic(30);
    test_reset_mid_write();
    test_uart();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmu_arbiter.md
Name: mmu_arbiter

Overview:
Memory arbiter/responder on the far side of the PC pause handshake. It owns the single shared 16-bit SRAM and serves instruction fetch at the current PC every cycle. It also serves MEM-stage load/store requests, which take priority. While a data access holds the bus, it raises vmem_pause_o so the PC and the upstream pipeline freeze, then releases them with a one-cycle completion pulse.

Parameters:
NOP_INST, 16'h0800, instruction word driven on if_inst_o after reset
RAM_AW, 18, SRAM address width; upper bits zero-filled

Ports:
clk  input  1  clock
rst  input  1  reset
if_addr_i  input  16  fetch address (PC)
if_pause_i  input  1  pipeline pause from PC (MMU_pause); freezes if_inst_o
if_inst_o  output  16  fetched instruction, registered
mem_req_i  input  1  MEM-stage access request, level, held until mem_done_o
mem_we_i  input  1  1 = store, 0 = load
mem_addr_i  input  16  data address
mem_wdata_i  input  16  store data
mem_rdata_o  output  16  load data, valid while mem_done_o=1, held afterwards
mem_done_o  output  1  one-cycle completion pulse
vmem_pause_o  output  1  structural-hazard stall to PC and pipeline
ram_addr_o  output  RAM_AW  SRAM address
ram_data_o  output  16  SRAM write data
ram_data_i  input  16  SRAM read data
ram_data_oe  output  1  1 = drive ram_data_o onto bus
ram_ce_n, ram_oe_n, ram_we_n  output  1 each  SRAM strobes, active low
uart_rd_o, uart_wr_o  output  1 each  UART strobes (optional feature)
uart_rdata_i  input  8  UART receive byte
uart_ready_i  input  1  UART receive data available
uart_tx_idle_i  input  1  UART transmitter idle

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- Reset values: state FETCH; if_inst_o=NOP_INST; mem_rdata_o=0; mem_done_o=0; ram_we_n=1, ram_oe_n=0, ram_ce_n=0; ram_data_oe=0; UART strobes 0.
- Reset asserted mid-access aborts the access: no done pulse, ram_we_n forced to 1 on the same edge.
- Request acceptance: accept = mem_req_i & ~mem_done_o, in state FETCH only.
- vmem_pause_o (combinational) = (state != FETCH) | accept.
- States:
  - FETCH: ram_addr_o = if_addr_i, oe active. On the edge: if accept, go to MEM_RD (load) or WR_SETUP (store) and latch mem_addr_i/mem_wdata_i. Else, if ~if_pause_i, if_inst_o <= ram_data_i; if if_pause_i, if_inst_o holds.
  - MEM_RD: ram_addr_o = latched address. On the edge: mem_rdata_o <= ram_data_i, mem_done_o <= 1, go to FETCH. Read latency is 2 edges from the accept edge.
  - WR_SETUP: address and data driven, ram_data_oe=1, oe inactive, we_n=1. Next state WR_PULSE.
  - WR_PULSE: we_n=0. Next state WR_HOLD.
  - WR_HOLD: we_n=1, data still driven. On the edge: mem_done_o <= 1, go to FETCH.
- if_inst_o never updates outside FETCH and holds across the whole access. The PC re-fetches after the stall.
- mem_done_o is high for exactly one FETCH cycle. No request can be accepted in that cycle, so a request held high cannot retrigger. Back-to-back requests are accepted in the following cycle.
- ram_addr_o = {zeros, 16-bit address}.

Optional Feature:
MMU_UART_EN
- Defined: addresses 0xBF00 and 0xBF01 go to the UART, not the SRAM.
  - Load 0xBF00: state UART_RD, uart_rd_o=1 for 1 cycle, data {8'b0, uart_rdata_i}.
  - Store 0xBF00: state UART_WR, uart_wr_o=1 for 1 cycle, ram_data_o = wdata.
  - Load 0xBF01: single MEM_RD-length access returning {14'b0, uart_ready_i, uart_tx_idle_i}.
  - Store 0xBF01 is ignored but still completes with done.
  - SRAM strobes stay inactive during all UART accesses.
- Undefined: all addresses go to the SRAM; uart_rd_o/uart_wr_o tied 0.

Test Plan:
- Reset, then rst=0, if_addr_i=0x0004, ram_data_i=0x4801 -> if_inst_o=0x0800 until first edge, then 0x4801; vmem_pause_o=0.
- Load at 0x0100, ram returns 0xBEEF -> vmem_pause_o high for 2 cycles; mem_done_o pulses 1 cycle; mem_rdata_o=0xBEEF; if_inst_o unchanged throughout.
- Store 0x1234 to 0x0200 -> ram_we_n low exactly 1 cycle (the middle of 3); ram_data_oe=1 for 3 cycles; ram_addr_o=0x00200; done after 3 cycles.
- mem_req_i held high across done, then a new store -> no retrigger in the done cycle; the second access starts on the next cycle.
- if_pause_i=1 with a changing ram_data_i in FETCH -> if_inst_o holds; rst pulsed in WR_PULSE -> we_n=1 next cycle, no done pulse, state FETCH.
- MMU_UART_EN: load 0xBF01 with ready=1, idle=1 -> 0x0003; store 0xBF00 -> uart_wr_o 1 cycle, ram_we_n stays 1.
